// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback stage.
package wb_pkg;

    typedef enum logic [1:0] {
        MSZ_B = 2'b00,
        MSZ_H = 2'b01,
        MSZ_W = 2'b10,
        MSZ_X = 2'b11
    } mem_size_t;

    typedef struct packed {
        logic [4:0]  rd_ind;
        logic [31:0] dat;
    } wb_entry_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // A write to x0 occupies its slot but must never strobe the register file.
    function automatic logic wr_enable(input logic [4:0] rd);
        return rd != REG_ZERO;
    endfunction

endpackage

// File: rtl/load_align.sv
// Extracts the addressed byte/half/word lane from a load word and extends it.
module load_align
    import wb_pkg::*;
(
    input  logic [31:0] mem_raw_i,
    input  logic [1:0]  mem_addr_lo_i,
    input  logic [1:0]  mem_size_i,
    input  logic        mem_unsigned_i,
    output logic [31:0] dat_o,
    output logic        misalign_o
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    function automatic logic [31:0] ext8(input logic [7:0] v, input logic uns);
        return uns ? {24'd0, v} : {{24{v[7]}}, v};
    endfunction

    function automatic logic [31:0] ext16(input logic [15:0] v, input logic uns);
        return uns ? {16'd0, v} : {{16{v[15]}}, v};
    endfunction

    assign byte_lane = mem_raw_i[{mem_addr_lo_i, 3'b000} +: 8];
    assign half_lane = mem_raw_i[{mem_addr_lo_i[1], 4'b0000} +: 16];

    always_comb begin
        dat_o      = '0;
        misalign_o = 1'b0;
        case (mem_size_t'(mem_size_i))
            MSZ_B: dat_o = ext8(byte_lane, mem_unsigned_i);
            MSZ_H: begin
                if (mem_addr_lo_i[0]) misalign_o = 1'b1;
                else                  dat_o      = ext16(half_lane, mem_unsigned_i);
            end
            MSZ_W: begin
                if (mem_addr_lo_i != 2'b00) misalign_o = 1'b1;
                else                        dat_o      = mem_raw_i;
            end
            default: misalign_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/writeback_unit.sv
// Final stage: merges ALU and load results into one in-order register-file write
// stream, buffering ALU results that lose arbitration in a small circular FIFO.
module writeback_unit
    import wb_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [4:0]  alu_rd_ind,
    input  logic [31:0] alu_dat,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [4:0]  mem_rd_ind,
    input  logic [31:0] mem_raw,
    input  logic [1:0]  mem_addr_lo,
    input  logic [1:0]  mem_size,
    input  logic        mem_unsigned,
    output logic [4:0]  rd_ind,
    output logic [31:0] rd_dat,
    output logic        rd_dat_take,
    output logic [31:0] mem_dat,
    output logic        mem_dat_take,
    output logic        mem_misalign
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    wb_entry_t       fifo_q [DEPTH];
    logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]   occ_q, occ_d;

    logic [4:0]      rd_ind_q, rd_ind_d;
    logic [31:0]     rd_dat_q, rd_dat_d;
    logic [31:0]     mem_dat_q, mem_dat_d;
    logic            rd_take_q, rd_take_d;
    logic            mem_take_q, mem_take_d;
    logic            mis_q, mis_d;

    logic            alu_acc, mem_acc;
    logic            push, pop, iss_alu, iss_mem;
    wb_entry_t       iss_ent, new_ent;
    logic [31:0]     la_dat;
    logic            la_mis;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    load_align u_align (
        .mem_raw_i      (mem_raw),
        .mem_addr_lo_i  (mem_addr_lo),
        .mem_size_i     (mem_size),
        .mem_unsigned_i (mem_unsigned),
        .dat_o          (la_dat),
        .misalign_o     (la_mis)
    );

    // Readies come from registered occupancy only; a full FIFO refuses even when popping.
    assign alu_ready = (occ_q < CW'(DEPTH));
    assign mem_ready = (occ_q == '0);
    assign alu_acc   = alu_valid & alu_ready;
    assign mem_acc   = mem_valid & mem_ready;
    assign new_ent   = '{rd_ind: alu_rd_ind, dat: alu_dat};

    // Buffered entries are oldest, then the load, then the new ALU result.
    always_comb begin
        pop     = 1'b0;
        push    = 1'b0;
        iss_alu = 1'b0;
        iss_mem = 1'b0;
        iss_ent = fifo_q[head_q];
        if (occ_q != '0) begin
            pop     = 1'b1;
            iss_alu = 1'b1;
            push    = alu_acc;
        end else if (mem_acc) begin
            iss_mem = 1'b1;
            push    = alu_acc;
        end else if (alu_acc) begin
            iss_alu = 1'b1;
            iss_ent = new_ent;
        end
    end

    always_comb begin
        head_d = pop  ? ptr_inc(head_q) : head_q;
        tail_d = push ? ptr_inc(tail_q) : tail_q;
        occ_d  = occ_q;
        if (push && !pop)      occ_d = occ_q + 1'b1;
        else if (pop && !push) occ_d = occ_q - 1'b1;
    end

    always_comb begin
        rd_ind_d   = rd_ind_q;
        rd_dat_d   = rd_dat_q;
        mem_dat_d  = mem_dat_q;
        rd_take_d  = 1'b0;
        mem_take_d = 1'b0;
        mis_d      = 1'b0;
        if (iss_alu) begin
            rd_ind_d  = iss_ent.rd_ind;
            rd_dat_d  = iss_ent.dat;
            rd_take_d = wr_enable(iss_ent.rd_ind);
        end else if (iss_mem) begin
            if (la_mis) begin
                mis_d = 1'b1;
            end else begin
                rd_ind_d   = mem_rd_ind;
                mem_dat_d  = la_dat;
                mem_take_d = wr_enable(mem_rd_ind);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            occ_q      <= '0;
            rd_ind_q   <= '0;
            rd_dat_q   <= '0;
            mem_dat_q  <= '0;
            rd_take_q  <= 1'b0;
            mem_take_q <= 1'b0;
            mis_q      <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            occ_q      <= occ_d;
            rd_ind_q   <= rd_ind_d;
            rd_dat_q   <= rd_dat_d;
            mem_dat_q  <= mem_dat_d;
            rd_take_q  <= rd_take_d;
            mem_take_q <= mem_take_d;
            mis_q      <= mis_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_q[tail_q] <= new_ent;
    end

    assign rd_ind       = rd_ind_q;
    assign rd_dat       = rd_dat_q;
    assign mem_dat      = mem_dat_q;
    assign rd_dat_take  = rd_take_q;
    assign mem_dat_take = mem_take_q;
    assign mem_misalign = mis_q;

endmodule
